// File: rtl/fifo_param.sv
// Parametrised transaction-layer FIFO with an internal control FSM.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_param #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH:0]   umbral_superior,
  input  logic [ADDR_WIDTH:0]   umbral_inferior,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic [2:0]            state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C =
    (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t                st;
  state_t                st_nx;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   cnt_nx;
  logic [ADDR_WIDTH:0]   thr_hi;
  logic [ADDR_WIDTH:0]   thr_lo;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic is_full;
  logic is_empty;
  logic run;
  logic under;
  logic over;
  logic wr_en;
  logic rd_en;
  logic flush;
  logic load_thr;

  assign is_full  = (cnt == DEPTH_C);
  assign is_empty = (cnt == '0);

  // Qualify requests: only IDLE/ACTIVE move data, init wins.
  always_comb begin
    run   = 1'b0;
    under = 1'b0;
    over  = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    run   = (st == S_IDLE || st == S_ACTIVE) && !init;
    under = run && pop && is_empty;
    over  = run && push && is_full && !pop;
    rd_en = run && pop && !is_empty;
    wr_en = run && push && !under && (!is_full || pop);
  end

  // Occupancy after this edge's accepted push/pop.
  always_comb begin
    cnt_nx = cnt;
    unique case ({wr_en, rd_en})
      2'b10:   cnt_nx = cnt + 1'b1;
      2'b01:   cnt_nx = cnt - 1'b1;
      default: cnt_nx = cnt;
    endcase
  end

  // Next-state logic for the control FSM.
  always_comb begin
    st_nx = st;
    unique case (st)
      S_RESET: st_nx = S_INIT;
      S_INIT: begin
        if (!init) st_nx = S_IDLE;
      end
      S_IDLE, S_ACTIVE: begin
        if (init)
          st_nx = S_INIT;
        else if (under || over)
          st_nx = S_ERROR;
        else if (cnt_nx == '0)
          st_nx = S_IDLE;
        else
          st_nx = S_ACTIVE;
      end
      S_ERROR: begin
        if (init) st_nx = S_INIT;
      end
      default: st_nx = S_RESET;
    endcase
  end

  assign flush    = (st_nx == S_INIT);
  assign load_thr = (st_nx == S_INIT) || (st == S_INIT);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_RESET;
    else       st <= st_nx;
  end

  // Pointers and count; entering or staying in INIT flushes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_nx;
    end
  end

  // Threshold registers track the ports while in INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_hi <= '0;
      thr_lo <= '0;
    end else if (load_thr) begin
      thr_hi <= umbral_superior;
      thr_lo <= umbral_inferior;
    end
  end

  // Error flag mirrors residence in ERROR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) error <= 1'b0;
    else       error <= (st_nx == S_ERROR);
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out  = mem[rd_ptr];
  assign valid_out = !is_empty;
`else
  // Registered read port with one cycle of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_en;
      if (rd_en) data_out <= mem[rd_ptr];
    end
  end
`endif

  assign full         = is_full;
  assign empty        = is_empty;
  assign almost_full  = (st != S_RESET) && (cnt >= thr_hi);
  assign almost_empty = (cnt <= thr_lo);
  assign fifo_count   = cnt;
  assign state        = st;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param with a queue-based reference model.
// Works for both read modes (FIFO_FWFT_EN defined or not).
module tb_fifo_param;

  logic       clk;
  logic       reset;
  logic       init;
  logic [3:0] uh;
  logic [3:0] ul;
  logic       push;
  logic [9:0] din;
  logic       pop;
  logic [9:0] dout;
  logic       vld;
  logic       full;
  logic       empty;
  logic       af;
  logic       ae;
  logic       err;
  logic [3:0] cnt;
  logic [2:0] st;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FIFO_FWFT_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  fifo_param #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .umbral_superior (uh),
    .umbral_inferior (ul),
    .push            (push),
    .data_in         (din),
    .pop             (pop),
    .data_out        (dout),
    .valid_out       (vld),
    .full            (full),
    .empty           (empty),
    .almost_full     (af),
    .almost_empty    (ae),
    .error           (err),
    .fifo_count      (cnt),
    .state           (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: states 0..4, contents as a queue.
  int         m_st = 0;
  int         m_hi = 0;
  int         m_lo = 0;
  logic [9:0] m_dout = '0;
  bit         m_vld = 1'b0;
  logic [9:0] q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st = 0;
      q.delete();
      m_hi = 0;
      m_lo = 0;
      m_dout = '0;
      m_vld = 1'b0;
    end else begin
      m_vld = 1'b0;
      case (m_st)
        0: begin
          m_st = 1;
          m_hi = int'(uh);
          m_lo = int'(ul);
        end
        1: begin
          m_hi = int'(uh);
          m_lo = int'(ul);
          if (!init) m_st = 2;
        end
        2, 3: begin
          if (init) begin
            q.delete();
            m_st = 1;
            m_hi = int'(uh);
            m_lo = int'(ul);
          end else if (pop && q.size() == 0) begin
            m_st = 4;
          end else if (push && !pop && q.size() == 8) begin
            m_st = 4;
          end else begin
            if (pop) begin
              m_dout = q.pop_front();
              m_vld = 1'b1;
            end
            if (push) q.push_back(din);
            m_st = (q.size() == 0) ? 2 : 3;
          end
        end
        4: begin
          if (init) begin
            q.delete();
            m_st = 1;
            m_hi = int'(uh);
            m_lo = int'(ul);
          end
        end
        default: m_st = 0;
      endcase
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm);
    int sz;
    sz = q.size();
    chk({nm, ".state"}, int'(st), m_st);
    chk({nm, ".count"}, int'(cnt), sz);
    chk({nm, ".full"}, int'(full), int'(sz == 8));
    chk({nm, ".empty"}, int'(empty), int'(sz == 0));
    chk({nm, ".afull"}, int'(af), int'(m_st != 0 && sz >= m_hi));
    chk({nm, ".aempty"}, int'(ae), int'(sz <= m_lo));
    chk({nm, ".error"}, int'(err), int'(m_st == 4));
`ifdef FIFO_FWFT_EN
    chk({nm, ".valid"}, int'(vld), int'(sz != 0));
    if (sz != 0) chk({nm, ".data"}, int'(dout), int'(q[0]));
`else
    chk({nm, ".valid"}, int'(vld), int'(m_vld));
    chk({nm, ".data"}, int'(dout), int'(m_dout));
`endif
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) check_all("cyc");

  task automatic cyc(input bit p, input logic [9:0] d, input bit r);
    push = p;
    din  = d;
    pop  = r;
    @(negedge clk);
  endtask

  logic [9:0] d;

  initial begin
    reset = 1'b1;
    init  = 1'b0;
    uh    = '0;
    ul    = '0;
    push  = 1'b0;
    din   = '0;
    pop   = 1'b0;
    @(negedge clk);
    chk("rst.state", int'(st), 0);
    chk("rst.empty", int'(empty), 1);
    chk("rst.aempty", int'(ae), 1);
    chk("rst.full", int'(full), 0);
    chk("rst.afull", int'(af), 0);

    reset = 1'b0;
    init  = 1'b1;
    uh    = 4'd6;
    ul    = 4'd2;
    cyc(0, 0, 0);
    chk("init.state", int'(st), 1);
    cyc(0, 0, 0);
    init = 1'b0;
    cyc(0, 0, 0);
    chk("idle.state", int'(st), 2);

    for (int i = 1; i <= 6; i++) begin
      cyc(1, 10'h3A0 + 10'(i), 0);
      if (i == 1) chk("push1.state", int'(st), 3);
      if (i == 2) chk("push2.aempty", int'(ae), 1);
      if (i == 3) chk("push3.aempty", int'(ae), 0);
      if (i == 5) chk("push5.afull", int'(af), 0);
      if (i == 6) chk("push6.afull", int'(af), 1);
    end
    chk("push6.count", int'(cnt), 6);
    cyc(1, 10'h3A7, 0);
    cyc(1, 10'h3A8, 0);
    chk("fill.full", int'(full), 1);

    cyc(1, 10'h3FF, 0);
    chk("ovf.error", int'(err), 1);
    chk("ovf.state", int'(st), 4);
    chk("ovf.count", int'(cnt), 8);
    cyc(1, 10'h111, 1);
    chk("err.ignore", int'(cnt), 8);
    init = 1'b1;
    cyc(0, 0, 0);
    chk("flush.state", int'(st), 1);
    chk("flush.count", int'(cnt), 0);
    chk("flush.error", int'(err), 0);
    init = 1'b0;
    cyc(0, 0, 0);

    for (int i = 0; i < 8; i++) cyc(1, 10'h100 + 10'(i), 0);
    chk("full8.full", int'(full), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 10'h200 + 10'(i), 1);
      chk("pp.data", int'(dout), 'h100 + i + LAG);
      chk("pp.valid", int'(vld), 1);
      chk("pp.full", int'(full), 1);
      chk("pp.error", int'(err), 0);
    end
    cyc(0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1);
    chk("drain.state", int'(st), 2);
    chk("drain.empty", int'(empty), 1);

    cyc(1, 10'h155, 1);
    chk("unf.state", int'(st), 4);
    chk("unf.error", int'(err), 1);
    chk("unf.valid", int'(vld), 0);
    chk("unf.count", int'(cnt), 0);
    cyc(1, 10'h156, 0);
    cyc(0, 0, 1);
    chk("unf.ignore", int'(cnt), 0);
    chk("unf.vld2", int'(vld), 0);
    init = 1'b1;
    cyc(0, 0, 0);
    init = 1'b0;
    cyc(0, 0, 0);

    d = 10'h300;
    cyc(1, d, 0);
    for (int r = 0; r < 10; r++) begin
      d = d + 10'd1;
      cyc(1, d, 0);
      d = d + 10'd1;
      cyc(1, d, 0);
      cyc(0, 0, 1);
      cyc(0, 0, 1);
    end
    chk("wrap.count", int'(cnt), 1);
    chk("wrap.data", int'(dout), 'h313 + LAG);

    for (int i = 0; i < 4; i++) cyc(1, 10'h3E0 + 10'(i), 0);
    chk("burst.count", int'(cnt), 5);
    push = 1'b1;
    din  = 10'h3EE;
    #2;
    reset = 1'b1;
    #1;
    chk("arst.state", int'(st), 0);
    chk("arst.count", int'(cnt), 0);
    chk("arst.empty", int'(empty), 1);
    chk("arst.full", int'(full), 0);
    chk("arst.afull", int'(af), 0);
    chk("arst.aempty", int'(ae), 1);
    chk("arst.error", int'(err), 0);
    chk("arst.valid", int'(vld), 0);
`ifndef FIFO_FWFT_EN
    chk("arst.data", int'(dout), 0);
`endif
    check_all("arst");
    @(negedge clk);
    reset = 1'b0;
    push  = 1'b0;
    init  = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    init = 1'b0;
    cyc(0, 0, 0);
    chk("post.state", int'(st), 2);
    chk("post.empty", int'(empty), 1);
    cyc(0, 0, 1);
    chk("post.valid", int'(vld), 0);
    chk("post.state2", int'(st), 4);
    cyc(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised successor to the fixed 10-bit, 8-entry transaction-layer FIFO. Width and depth are set by parameters.
- Adds explicit full/empty flags, an occupancy count, overflow/underflow error detection and an internal control FSM, replacing the externally driven state input.
- Almost-full/almost-empty thresholds (umbral_superior/umbral_inferior) are latched during an INIT phase.
- Instantiated per virtual channel between the transaction-layer arbiter and the link-side buffers.

Parameters:
- DATA_WIDTH, 10, bits per entry.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- init  in  1  level; holds/enters INIT state, thresholds sampled while high.
- umbral_superior  in  ADDR_WIDTH+1  almost-full threshold (sampled in INIT only).
- umbral_inferior  in  ADDR_WIDTH+1  almost-empty threshold (sampled in INIT only).
- push  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- pop  in  1  read request.
- data_out  out  DATA_WIDTH  read data.
- valid_out  out  1  data_out holds valid read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= registered umbral_superior.
- almost_empty  out  1  count <= registered umbral_inferior.
- error  out  1  overflow/underflow occurred; sticky while in ERROR.
- fifo_count  out  ADDR_WIDTH+1  current occupancy.
- state  out  3  FSM state for debug/probador.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - Pointers, count, data_out, valid_out, error and thresholds go to 0.
  - Resulting outputs: state=RESET, empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not cleared.
- FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- FSM transitions:
  - RESET -> INIT on first clk edge with reset low.
  - INIT:
    - Threshold registers load from the ports every cycle; pointers and count are held at 0.
    - push/pop are ignored.
    - init=0 -> IDLE.
  - IDLE (count==0):
    - Accepted push -> ACTIVE.
    - pop -> underflow.
    - init=1 -> INIT.
  - ACTIVE:
    - Transition to IDLE in the cycle the count becomes 0.
    - init=1 -> INIT, which flushes pointers and count.
  - ERROR:
    - error=1 is held and push/pop are ignored.
    - Exits only by init=1 (-> INIT, flush) or reset.
- Overflow: push with full=1 and no pop in the same cycle. Write is dropped, then next state = ERROR.
- Underflow: pop with empty=1. No read occurs; any simultaneous push is dropped; next state = ERROR.
- Simultaneous push+pop:
  - When 0 < count < DEPTH: both occur and count is unchanged.
  - When full: both occur, count stays DEPTH, no error.
- Pointers wrap modulo DEPTH. count is ADDR_WIDTH+1 bits, range 0..DEPTH.
- Flags are combinational from the registered count and registered thresholds; they are valid the cycle after the causing push/pop edge.
- Threshold values above DEPTH are legal: almost_full then never asserts, and almost_empty is always asserted.
- Read timing (default, macro undefined):
  - Pop in cycle N: data_out is registered with the head entry at edge N+1, and valid_out=1 for exactly that cycle.
  - Without a pop, valid_out=0 and data_out holds its last value.

Optional Feature:
- FIFO_FWFT_EN: first-word-fall-through.
- Defined:
  - data_out is driven combinationally from the head entry and valid_out = !empty, with zero read latency.
  - pop acknowledges/consumes the shown word; the next word appears the cycle after the pop edge.
- Undefined: registered 1-cycle read latency as described under Behaviour.
- FSM, flags and error rules are identical in both modes.

Test Plan:
- Defaults (DATA_WIDTH=10, ADDR_WIDTH=3):
  - Reset, init=1 with umbral_superior=6, umbral_inferior=2, then init=0.
  - Push 0x3A1..0x3A6 -> state IDLE->ACTIVE; almost_empty drops after the 3rd push and almost_full rises after the 6th push; fifo_count=6.
- Fill to 8:
  - Push with full=1 and pop=0 -> data dropped, error=1, state=ERROR.
  - Then init=1 -> INIT, fifo_count=0, error=0.
- Count=8, simultaneous push+pop for 4 cycles -> full stays 1, no error; popped data is in FIFO order with a 1-cycle lag (FWFT off).
- Pop on empty FIFO in IDLE -> error=1, state=ERROR, valid_out stays 0; further push/pop are ignored.
- Wrap: 20 push/pop pairs with count oscillating 1..3 -> data in order across pointer wrap; no flag glitches.
- Assert reset mid-burst at count=5 -> all outputs at reset values immediately, without waiting for a clk edge; after reset low and init, FIFO is empty and the old data is not readable.
